// File: rtl/wide_add_pkg.sv
// Shared definitions for the wide add/subtract operand sequencer.
//   state_e        : sequencer FSM states (IDLE, RUN, DONE)
//   DEF_N          : default adder word width
//   DEF_WORDS      : default number of words per operand
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_N     = 8;
    localparam int DEF_WORDS = 4;

endpackage

// File: rtl/wide_add_word_slicer.sv
// Combinational word selector for the wide add sequencer.
// Picks word k of the latched operands and applies the subtract inversion to B.
// Both words are forced to zero when en is low so the adder sees idle inputs.
// Ports:
//   en      in  1        drive the selected words (high only in RUN)
//   k       in  KW       word index
//   sub     in  1        1 = invert B word (A - B)
//   a_full  in  N*WORDS  latched operand A
//   b_full  in  N*WORDS  latched operand B
//   a_word  out N        word k of A
//   b_word  out N        word k of B, inverted when sub = 1
module wide_add_word_slicer
    import wide_add_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int WORDS = DEF_WORDS,
    parameter int KW    = $clog2(WORDS)
) (
    input  logic                 en,
    input  logic [KW-1:0]        k,
    input  logic                 sub,
    input  logic [N*WORDS-1:0]   a_full,
    input  logic [N*WORDS-1:0]   b_full,
    output logic [N-1:0]         a_word,
    output logic [N-1:0]         b_word
);

    // Select word k and apply the two's-complement inversion for subtract.
    always_comb begin
        a_word = {N{1'b0}};
        b_word = {N{1'b0}};
        if (en) begin
            a_word = a_full[int'(k)*N +: N];
            b_word = b_full[int'(k)*N +: N] ^ {N{sub}};
        end else begin
            a_word = {N{1'b0}};
            b_word = {N{1'b0}};
        end
    end

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-cycle operand sequencer for an external N-bit combinational adder.
// Accepts a W = N*WORDS bit add/subtract request, feeds one word pair per
// cycle into the adder (LSW first), chains the carry and returns the W-bit
// result on a valid/ready output.
// Optional feature: define WIDE_ADD_OVF_EN to add the out_ovf signed-overflow
// output and its logic.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     request handshake; in_a, in_b, in_sub request data
//   out_valid/out_ready   result handshake; out_sum, out_cout (, out_ovf)
//   add_a/add_b/add_cin   word pair driven to the adder
//   add_sum/add_cout      adder result, sampled in the same cycle
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int WORDS = DEF_WORDS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WORDS-1:0]   in_a,
    input  logic [N*WORDS-1:0]   in_b,
    input  logic                 in_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WORDS-1:0]   out_sum,
    output logic                 out_cout,
`ifdef WIDE_ADD_OVF_EN
    output logic                 out_ovf,
`endif
    output logic [N-1:0]         add_a,
    output logic [N-1:0]         add_b,
    output logic                 add_cin,
    input  logic [N-1:0]         add_sum,
    input  logic                 add_cout
);

    localparam int KW = $clog2(WORDS);
    localparam int W  = N * WORDS;

    state_e          state_r;
    state_e          state_s;
    logic [KW-1:0]   k_r;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic            sub_r;
    logic [W-1:0]    sum_r;
    logic            carry_r;
    logic            run_s;
    logic            last_s;
    logic            accept_s;

    assign run_s    = (state_r == RUN);
    assign last_s   = (k_r == KW'(WORDS - 1));
    assign accept_s = (state_r == IDLE) && in_valid;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; DONE never re-accepts in the same cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (in_valid)  state_s = RUN;  else state_s = IDLE;
            RUN:     if (last_s)    state_s = DONE; else state_s = RUN;
            DONE:    if (out_ready) state_s = IDLE; else state_s = DONE;
            default: state_s = IDLE;
        endcase
    end

    // FSM outputs: handshakes and the carry-in of the current word.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_cin   = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready = 1'b1;
            end
            RUN: begin
                // Subtract injects the +1 of two's complement on the first word.
                if (k_r == {KW{1'b0}}) begin
                    add_cin = sub_r;
                end else begin
                    add_cin = carry_r;
                end
            end
            DONE: begin
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                add_cin   = 1'b0;
            end
        endcase
    end

    wide_add_word_slicer #(
        .N     (N),
        .WORDS (WORDS),
        .KW    (KW)
    ) u_slicer (
        .en     (run_s),
        .k      (k_r),
        .sub    (sub_r),
        .a_full (a_r),
        .b_full (b_r),
        .a_word (add_a),
        .b_word (add_b)
    );

    // Operand latch, word counter, result and carry capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            sub_r   <= 1'b0;
            k_r     <= {KW{1'b0}};
            sum_r   <= {W{1'b0}};
            carry_r <= 1'b0;
        end else if (accept_s) begin
            a_r   <= in_a;
            b_r   <= in_b;
            sub_r <= in_sub;
            k_r   <= {KW{1'b0}};
        end else if (run_s) begin
            sum_r[int'(k_r)*N +: N] <= add_sum;
            carry_r                 <= add_cout;
            // Hold at the last word instead of wrapping.
            if (!last_s) begin
                k_r <= k_r + KW'(1'b1);
            end
        end
    end

    assign out_sum  = sum_r;
    assign out_cout = carry_r;

`ifdef WIDE_ADD_OVF_EN
    logic ovf_r;

    // Signed overflow from the MSBs of the top word pair and its sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (accept_s) begin
            ovf_r <= 1'b0;
        end else if (run_s && last_s) begin
            ovf_r <= (add_a[N-1] == add_b[N-1]) && (add_sum[N-1] != add_a[N-1]);
        end
    end

    assign out_ovf = ovf_r;
`endif

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer (N=8, WORDS=4) with a
// behavioural adder attached and a 32-bit arithmetic reference model.
// Define WIDE_ADD_OVF_EN to also check out_ovf.
module tb_wide_add_sequencer;

    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
`ifdef WIDE_ADD_OVF_EN
    logic          out_ovf;
`endif
    logic [N-1:0]  add_a;
    logic [N-1:0]  add_b;
    logic          add_cin;
    logic [N-1:0]  add_sum;
    logic          add_cout;

    int ncmp  = 0;
    int nfail = 0;
    int cyc   = 0;
    int last_acc = 0;

    wide_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
`ifdef WIDE_ADD_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    // Behavioural combinational N-bit adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: whole-word arithmetic on 32-bit values.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         output logic [W-1:0] s, output logic c, output logic v);
        logic [W:0] u;
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            u = {1'b0, a} - {1'b0, b};
            c = ~u[W];
            r = sa - sb;
        end else begin
            u = {1'b0, a} + {1'b0, b};
            c = u[W];
            r = sa + sb;
        end
        s = u[W-1:0];
        v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endtask

    // One request: wait for in_ready, accept, scramble inputs, wait for result, check.
    task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input string tag, output logic first_cin, output logic [N-1:0] first_b);
        logic [W-1:0] es;
        logic ec;
        logic ev;
        int n;
        model(a, b, sub, es, ec, ev);
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        check({tag, "_accept_timeout"}, 64'(n >= 50), 64'd0);
        tick();
        last_acc = cyc;
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom_range(0, 1));
        first_cin = add_cin;
        first_b   = add_b;
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        check({tag, "_latency"}, 64'(n), 64'(WORDS));
        check({tag, "_sum"},  64'(out_sum),  64'(es));
        check({tag, "_cout"}, 64'(out_cout), 64'(ec));
`ifdef WIDE_ADD_OVF_EN
        check({tag, "_ovf"},  64'(out_ovf),  64'(ev));
`endif
    endtask

    initial begin
        logic          fc;
        logic [N-1:0]  fb;
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;
        logic          rs;
        int            prev_acc;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
        tick(); tick();
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum",   64'(out_sum),   64'd0);
        check("rst_out_cout",  64'(out_cout),  64'd0);
        check("rst_add_a",     64'(add_a),     64'd0);
        check("rst_add_b",     64'(add_b),     64'd0);
        check("rst_add_cin",   64'(add_cin),   64'd0);
`ifdef WIDE_ADD_OVF_EN
        check("rst_out_ovf",   64'(out_ovf),   64'd0);
`endif
        rst_n = 1'b1;
        tick();

        // All-ones plus one: full carry ripple.
        txn(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "wrap", fc, fb);
        check("wrap_sum_const", 64'(out_sum), 64'h0);
        check("wrap_cout_const", 64'(out_cout), 64'd1);
        tick();
        check("wrap_idle_ready", 64'(in_ready), 64'd1);

        // Zero minus one: borrow, first carry-in injected.
        txn(32'h0000_0000, 32'h0000_0001, 1'b1, "borrow", fc, fb);
        check("borrow_first_cin", 64'(fc), 64'd1);
        check("borrow_first_b",   64'(fb), 64'hFE);
        check("borrow_sum_const", 64'(out_sum), 64'hFFFF_FFFF);
        check("borrow_cout_const", 64'(out_cout), 64'd0);
        tick();

        // Backpressure: result held stable, no accept.
        out_ready = 1'b0;
        txn(32'h1234_5678, 32'h1111_1111, 1'b0, "bp", fc, fb);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_sum",   64'(out_sum),   64'h2345_6789);
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready",   64'(in_ready),  64'd0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_idle_ready", 64'(in_ready),  64'd1);
        check("bp_idle_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset in RUN at k = 2.
        in_a = 32'hA1B2_C3D4; in_b = 32'h0101_0101; in_sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        check("rstrun_add_a_k2", 64'(add_a), 64'hB2);
        rst_n = 1'b0;
        #1;
        check("rstrun_out_valid", 64'(out_valid), 64'd0);
        check("rstrun_in_ready",  64'(in_ready),  64'd1);
        check("rstrun_add_a",     64'(add_a),     64'd0);
        #2;
        rst_n = 1'b1;
        tick();
        txn(32'h0000_0001, 32'h0000_0001, 1'b0, "after_rst", fc, fb);
        check("after_rst_sum_const", 64'(out_sum), 64'h2);
        tick();

`ifdef WIDE_ADD_OVF_EN
        txn(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "ovf_pos", fc, fb);
        check("ovf_pos_const", 64'(out_ovf), 64'd1);
        tick();
        txn(32'h8000_0000, 32'h0000_0001, 1'b1, "ovf_neg", fc, fb);
        check("ovf_neg_const", 64'(out_ovf), 64'd1);
        tick();
        txn(32'h0000_0005, 32'h0000_0003, 1'b0, "ovf_none", fc, fb);
        check("ovf_none_const", 64'(out_ovf), 64'd0);
        tick();
`endif

        // Back-to-back random requests with out_ready held high.
        out_ready = 1'b1;
        prev_acc = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            txn(ra, rb, rs, "rand", fc, fb);
            if (i > 0) begin
                check("rand_throughput", 64'(last_acc - prev_acc), 64'(WORDS + 2));
            end
            prev_acc = last_acc;
        end
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
